relu_pool: RTL and testbench

//  Post-processing stage directly downstream of the PE array: consumes the signed 8-bit

---
 rtl/drl_pkg.sv | 28 ++
 rtl/pool_row_buf.sv | 30 +++
 rtl/relu_pool.sv | 190 +++++++++++++++++++
 tb/tb_relu_pool.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/drl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drl_pkg : shared types, pool-size helper and default pixel width           |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
package drl_pkg;

  localparam int DRL_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    POOL_NONE = 2'd0,
    POOL_2    = 2'd1,
    POOL_3    = 2'd2,
    POOL_4    = 2'd3
  } pool_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic [2:0] pool_size(input pool_mode_e m);
    return {1'b0, m} + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_row_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pool_row_buf : 1R1W partial-result row buffer, async read, sync write      |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module pool_row_buf
  import drl_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/relu_pool.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | relu_pool : ReLU + PxP max (optionally average, POOL_AVG_EN) pooling      |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module relu_pool
  import drl_pkg::*;
#(
  parameter int DATA_WIDTH = DRL_DATA_WIDTH,
  parameter int MAX_FMAP_W = 64,
  parameter int DIM_WIDTH  = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_relu,
  input  logic [1:0]            i_pool,
`ifdef POOL_AVG_EN
  input  logic                  i_avg,
`endif
  input  logic [DIM_WIDTH-1:0]  i_fmap_w,
  input  logic [DIM_WIDTH-1:0]  i_fmap_h,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int RB_DEPTH = MAX_FMAP_W / 2;
  localparam int AW       = $clog2(RB_DEPTH);
`ifdef POOL_AVG_EN
  localparam int ACC_W    = DATA_WIDTH + 4;
`else
  localparam int ACC_W    = DATA_WIDTH;
`endif
  localparam logic [DIM_WIDTH-1:0] C_DIM_ONE = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]        C_OC_ONE  = {{(AW-1){1'b0}}, 1'b1};

  state_e                  r_state, w_state_nxt;
  pool_mode_e              r_pmode;
  logic                    r_relu;
  logic [DIM_WIDTH-1:0]    r_w, r_h, r_col, r_row;
  logic [1:0]              r_pc, r_pr;
  logic [AW-1:0]           r_oc;
  logic signed [ACC_W-1:0] r_hacc;
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_data;

  logic [2:0]                   w_psize;
  logic [1:0]                   w_plast;
  logic                         w_avg, w_acc, w_wlast, w_hlast, w_col_last, w_row_last;
  logic signed [DATA_WIDTH-1:0] w_x8;
  logic signed [ACC_W-1:0]      w_x, w_h, w_rb_rd, w_rb_new, w_out_full;
  logic [DATA_WIDTH-1:0]        w_out;

  // Max in pooling mode, running sum in average mode.
  function automatic logic signed [ACC_W-1:0] combine(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b,
                                                      input logic avg);
    if (avg) return a + b;
    return (a > b) ? a : b;
  endfunction

  assign w_psize = pool_size(r_pmode);
  assign w_plast = 2'(w_psize - 3'd1);

`ifdef POOL_AVG_EN
  logic r_avg;
  assign w_avg = r_avg & ((w_psize == 3'd2) | (w_psize == 3'd4));
`else
  assign w_avg = 1'b0;
`endif

  assign w_x8       = (r_relu && i_data[DATA_WIDTH-1]) ? '0 : i_data;
  assign w_x        = ACC_W'(w_x8);
  assign w_acc      = i_valid & o_ready;
  assign w_wlast    = (r_pc == w_plast);
  assign w_hlast    = (r_pr == w_plast);
  assign w_col_last = (r_col == r_w - C_DIM_ONE);
  assign w_row_last = (r_row == r_h - C_DIM_ONE);
  assign w_h        = (r_pc == 2'd0) ? w_x : combine(r_hacc, w_x, w_avg);
  assign w_rb_new   = (r_pr == 2'd0) ? w_h : combine(w_rb_rd, w_h, w_avg);

  always_comb begin
    w_out_full = w_rb_new;
    if (w_avg) w_out_full = (w_psize == 3'd2) ? (w_rb_new >>> 2) : (w_rb_new >>> 4);
  end
  assign w_out = w_out_full[DATA_WIDTH-1:0];

  pool_row_buf #(
    .DEPTH (RB_DEPTH),
    .WIDTH (ACC_W)
  ) u_row_buf (
    .i_clk   (i_clk),
    .i_we    (w_acc & w_wlast),
    .i_waddr (r_oc),
    .i_wdata (w_rb_new),
    .i_raddr (r_oc),
    .o_rdata (w_rb_rd)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_busy      = (r_state != IDLE);
    o_done      = 1'b0;
    unique case (r_state)
      IDLE:  if (i_start) w_state_nxt = RUN;
      RUN: begin
        o_ready = ~r_valid | i_ready;
        if (i_valid && o_ready && w_col_last && w_row_last) w_state_nxt = FLUSH;
      end
      FLUSH: if (!r_valid) begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pmode <= POOL_NONE;
      r_relu  <= 1'b0;
      r_w     <= '0;
      r_h     <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_pc    <= '0;
      r_pr    <= '0;
      r_oc    <= '0;
      r_hacc  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
`ifdef POOL_AVG_EN
      r_avg   <= 1'b0;
`endif
    end else begin
      if (r_state == IDLE && i_start) begin
        r_pmode <= pool_mode_e'(i_pool);
        r_relu  <= i_relu;
        r_w     <= i_fmap_w;
        r_h     <= i_fmap_h;
`ifdef POOL_AVG_EN
        r_avg   <= i_avg;
`endif
        r_col   <= '0;
        r_row   <= '0;
        r_pc    <= '0;
        r_pr    <= '0;
        r_oc    <= '0;
      end else if (w_acc) begin
        r_hacc <= w_h;
        // Row end abandons any partial window, so trailing columns never complete.
        if (w_col_last) begin
          r_col <= '0;
          r_pc  <= '0;
          r_oc  <= '0;
          r_row <= r_row + C_DIM_ONE;
          r_pr  <= w_hlast ? 2'd0 : r_pr + 2'd1;
        end else begin
          r_col <= r_col + C_DIM_ONE;
          r_pc  <= w_wlast ? 2'd0 : r_pc + 2'd1;
          if (w_wlast) r_oc <= r_oc + C_OC_ONE;
        end
      end

      if (w_acc && w_wlast && w_hlast) begin
        r_valid <= 1'b1;
        r_data  <= w_out;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_relu_pool.sv
`default_nettype none
// Self-checking bench for relu_pool: directed vector table, reset corner case,
// and randomized frames compared against a window-level reference model.
module tb_relu_pool;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, relu = 1'b0;
  logic       valid = 1'b0, ready = 1'b0;
  logic [1:0] pool = 2'd0;
  logic [6:0] fw = 7'd0, fh = 7'd0;
  logic [7:0] din = 8'd0;
  logic       o_ready, o_valid, o_busy, o_done;
  logic [7:0] dout;
`ifdef POOL_AVG_EN
  logic       avg = 1'b0;
`endif

  always #5 clk = ~clk;

  relu_pool dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_relu   (relu),
    .i_pool   (pool),
`ifdef POOL_AVG_EN
    .i_avg    (avg),
`endif
    .i_fmap_w (fw),
    .i_fmap_h (fh),
    .i_valid  (valid),
    .i_data   (din),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_data   (dout),
    .i_ready  (ready),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  typedef struct {
    int w, h, p, rl, av, kind, rmode, n;
    int e0, e1, e2, e3;
    int px0, px1, px2, px3;
  } vec_t;

  vec_t vecs[$];
  int   frame[$];
  int   got[$];
  int   expq[$];
  int   total = 0, bad = 0;
  int   ready_mode = 0;
  logic tog = 1'b0;

  // Downstream ready: 0 = always, 1 = alternating 1010..., other = random
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: ready = 1'b1;
      1: begin tog = ~tog; ready = tog; end
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && o_valid && ready) got.push_back(int'($signed(dout)));
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got=%0d want=finish", 0);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference: for every complete PxP window, ReLU each pixel, then max or floor-average.
  function automatic void model(input int w, input int h, input int p, input int rl, input int av);
    expq.delete();
    for (int orow = 0; orow < h / p; orow++)
      for (int ocol = 0; ocol < w / p; ocol++) begin
        int best, sum, v;
        best = -1000;
        sum  = 0;
        for (int dr = 0; dr < p; dr++)
          for (int dc = 0; dc < p; dc++) begin
            v = frame[(orow * p + dr) * w + ocol * p + dc];
            if (rl != 0 && v < 0) v = 0;
            sum += v;
            if (v > best) best = v;
          end
        if (av != 0 && (p == 2 || p == 4)) expq.push_back(sum >>> ((p == 2) ? 2 : 4));
        else                               expq.push_back(best);
      end
  endfunction

  function automatic void add(input int w, input int h, input int p, input int rl, input int av,
                              input int kind, input int rmode, input int n,
                              input int e0, input int e1, input int e2, input int e3,
                              input int px0, input int px1, input int px2, input int px3);
    vec_t t;
    t.w = w; t.h = h; t.p = p; t.rl = rl; t.av = av; t.kind = kind; t.rmode = rmode; t.n = n;
    t.e0 = e0; t.e1 = e1; t.e2 = e2; t.e3 = e3;
    t.px0 = px0; t.px1 = px1; t.px2 = px2; t.px3 = px3;
    vecs.push_back(t);
  endfunction

  function automatic int pick(input int i, input int a, input int b, input int c, input int d);
    case (i)
      0: return a;
      1: return b;
      2: return c;
      default: return d;
    endcase
  endfunction

  task automatic do_frame(input int w, input int h, input int p, input int rl, input int av,
                          input int rmode, input int gaps, input string nm);
    int n;
    bit acc, seen;
    got.delete();
    ready_mode = rmode;
    @(posedge clk); #1;
    start = 1'b1; fw = 7'(w); fh = 7'(h); pool = 2'(p - 1); relu = rl[0];
`ifdef POOL_AVG_EN
    avg = av[0];
`endif
    @(posedge clk); #1;
    // Scramble live config: the DUT must use the latched copy
    start = 1'b0; fw = 7'd1; fh = 7'd1; pool = ~pool; relu = ~relu;
    for (int k = 0; k < frame.size(); k++) begin
      if (gaps != 0) begin
        repeat ($urandom_range(0, 1)) begin valid = 1'b0; @(posedge clk); #1; end
      end
      valid = 1'b1;
      din   = 8'(frame[k]);
      n = 0; acc = 1'b0;
      while (!acc && n < 200) begin
        @(negedge clk); acc = o_ready;
        @(posedge clk); #1; n++;
      end
      if (!acc) begin
        chk({nm, " accept_timeout"}, 0, 1);
        break;
      end
    end
    valid = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 400) begin
      @(negedge clk); seen = o_done; n++;
    end
    chk({nm, " done"}, int'(seen), 1);
    @(negedge clk);
    chk({nm, " busy_after_done"}, int'(o_busy), 0);
    model(w, h, p, rl, av);
    chk({nm, " model_count"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      chk($sformatf("%s model_out%0d", nm, i), got[i], expq[i]);
  endtask

  initial begin
    vec_t v;
    int   w, h, p, rl, av;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset o_valid", int'(o_valid), 0);
    chk("reset o_data",  int'(dout),    0);
    chk("reset o_ready", int'(o_ready), 0);
    chk("reset o_busy",  int'(o_busy),  0);
    chk("reset o_done",  int'(o_done),  0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // w, h, P, relu, avg, kind(0 ramp,1 const -5,2 explicit,3 random), ready mode, n, e0..e3, px0..px3
    add(4, 4, 2, 0, 0, 0, 0, 4,  5,  7, 13, 15,  0, 0, 0, 0);
    add(4, 4, 2, 1, 0, 1, 0, 4,  0,  0,  0,  0,  0, 0, 0, 0);
    add(4, 4, 2, 0, 0, 1, 2, 4, -5, -5, -5, -5,  0, 0, 0, 0);
    add(7, 7, 3, 0, 0, 0, 0, 4, 16, 19, 37, 40,  0, 0, 0, 0);
    add(4, 4, 1, 0, 0, 0, 1, 16, 0,  1,  2,  3,  0, 0, 0, 0);
    add(8, 4, 4, 0, 0, 0, 2, 2, 27, 31,  0,  0,  0, 0, 0, 0);
    add(1, 3, 2, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0, 0, 0, 0);
    add(5, 1, 4, 1, 0, 3, 2, 0,  0,  0,  0,  0,  0, 0, 0, 0);
    add(2, 2, 1, 1, 0, 2, 0, 4,  0,  0,  0, 127, -128, -1, 0, 127);
`ifdef POOL_AVG_EN
    add(2, 2, 2, 0, 1, 2, 0, 1,  2,  0,  0,  0,  1,  2,  3,  4);
    add(2, 2, 2, 0, 1, 2, 0, 1, -2,  0,  0,  0, -1, -1, -1, -2);
    add(3, 3, 3, 0, 1, 0, 0, 1,  8,  0,  0,  0,  0,  0,  0,  0);
`endif

    for (int t = 0; t < vecs.size(); t++) begin
      v = vecs[t];
      frame.delete();
      for (int k = 0; k < v.w * v.h; k++) begin
        case (v.kind)
          0: frame.push_back(k);
          1: frame.push_back(-5);
          2: frame.push_back(pick(k, v.px0, v.px1, v.px2, v.px3));
          default: frame.push_back(int'($urandom_range(0, 255)) - 128);
        endcase
      end
      do_frame(v.w, v.h, v.p, v.rl, v.av, v.rmode, 0, $sformatf("vec%0d", t));
      if (v.kind != 3) begin
        chk($sformatf("vec%0d count", t), got.size(), v.n);
        for (int i = 0; i < v.n && i < 4 && i < got.size(); i++)
          chk($sformatf("vec%0d out%0d", t, i), got[i], pick(i, v.e0, v.e1, v.e2, v.e3));
      end
    end

    // Reset mid-frame after 5 pixels, pass-through mode; also checks 1-cycle latency
    got.delete();
    ready_mode = 0;
    @(posedge clk); #1;
    start = 1'b1; fw = 7'd4; fh = 7'd4; pool = 2'd0; relu = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid = 1'b1; din = 8'(k + 10);
      @(negedge clk);
      if (k == 0) chk("midrst busy", int'(o_busy), 1);
      if (k == 1) begin
        chk("latency o_valid", int'(o_valid), 1);
        chk("latency o_data",  int'(dout),    10);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst o_valid", int'(o_valid), 0);
    chk("midrst o_busy",  int'(o_busy),  0);
    chk("midrst o_ready", int'(o_ready), 0);
    chk("midrst outputs_before", got.size(), 4);
    valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    frame.delete();
    for (int k = 0; k < 16; k++) frame.push_back(k);
    do_frame(4, 4, 2, 0, 0, 1, 0, "after_reset");
    chk("after_reset count", got.size(), 4);
    if (got.size() > 0) chk("after_reset out0", got[0], 5);

    // Widest frame exercises the full row-buffer depth
    frame.delete();
    for (int k = 0; k < 64 * 2; k++) frame.push_back(int'($urandom_range(0, 255)) - 128);
    do_frame(64, 2, 2, 0, 0, 2, 0, "wide64");

    for (int r = 0; r < 8; r++) begin
      w  = int'($urandom_range(1, 20));
      h  = int'($urandom_range(1, 8));
      p  = int'($urandom_range(1, 4));
      rl = int'($urandom_range(0, 1));
`ifdef POOL_AVG_EN
      av = int'($urandom_range(0, 1));
`else
      av = 0;
`endif
      frame.delete();
      for (int k = 0; k < w * h; k++) frame.push_back(int'($urandom_range(0, 255)) - 128);
      do_frame(w, h, p, rl, av, 2, 1, $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
